acc_run_ctrl: RTL

//  Command-driven sequencer for the single-clock accumulator datapath. Accepts a
//  run command (step, cycle count, optional clear) over a valid/ready handshake.

---
 rtl/acc_run_ctrl_if.sv | 22 ++
 rtl/acc_run_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/acc_run_ctrl_if.sv
// Command channel for acc_run_ctrl: a run request (step, count, clear) offered
// over a valid/ready handshake.
interface acc_run_ctrl_if #(
  parameter int ADD_WIDTH = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADD_WIDTH-1:0] cmd_step;
  logic [CNT_WIDTH-1:0] cmd_count;
  logic                 cmd_clear;

  modport master (
    output cmd_valid, cmd_step, cmd_count, cmd_clear,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_step, cmd_count, cmd_clear,
    output cmd_ready
  );
endinterface

// File: rtl/acc_run_ctrl.sv
// Run sequencer for the accumulator datapath: takes one command at a time,
// drives clear/enable/add_value for the requested cycles, counts MSB wraps.
module acc_run_ctrl #(
  parameter int ADD_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  acc_run_ctrl_if.slave        cmd,
  input  logic                 abort,
  input  logic                 acc_msb,
  output logic                 acc_clr,
  output logic                 acc_en,
  output logic [ADD_WIDTH-1:0] add_value,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] remaining,
  output logic [CNT_WIDTH-1:0] wrap_count
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [ADD_WIDTH-1:0] step_q;
  logic                 msb_p1;
  logic                 en_p1;
  logic                 accept;
  logic                 wrap_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign cmd.cmd_ready = (state == S_IDLE) && !abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign add_value     = acc_en ? step_q : '0;
  // en_p1/msb_p1 line up with the datapath's one-cycle latency, so the add
  // issued on the final enabled cycle is still observed here.
  assign wrap_hit      = en_p1 && msb_p1 && !acc_msb;

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd.cmd_count == '0)  state_nxt = S_DONE;
          else if (cmd.cmd_clear)   state_nxt = S_CLEAR;
          else                      state_nxt = S_RUN;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_nxt = S_DONE;
        end else begin
          acc_clr   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_DONE;
        end else begin
          acc_en = 1'b1;
          if (remaining == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: control state, run bookkeeping and wrap detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      step_q     <= '0;
      remaining  <= '0;
      aborted    <= 1'b0;
      wrap_count <= '0;
      msb_p1     <= 1'b0;
      en_p1      <= 1'b0;
    end else begin
      state  <= state_nxt;
      msb_p1 <= acc_msb;
      en_p1  <= acc_en;
      if (accept) begin
        step_q     <= cmd.cmd_step;
        remaining  <= cmd.cmd_count;
        aborted    <= 1'b0;
        wrap_count <= '0;
      end else begin
        if (acc_en) remaining <= remaining - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (abort && (state == S_CLEAR || state == S_RUN)) aborted <= 1'b1;
        if (wrap_hit) wrap_count <= sat_inc(wrap_count);
      end
    end
  end

endmodule
